mem_arbiter: RTL and testbench

Two-client memory request arbiter that sits directly upstream of the memory controller's high-level interface (mem_addr / mem_data_in / mem_r_en / mem_w_en / mem_rdy / mem_cplt / mem_data_out). It serialises requests from an instruction-fetch client (port 0) and a data client (port 1) into a single outstanding transaction, with round-robin fairness. It returns each completion and its read data to the originating client, and a watchdog terminates any transaction the controller never completes.

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of the memory controller's request interface.
// One transaction outstanding at a time; completions are routed back to the owner, and a
// watchdog force-completes (with err) any transaction the controller never finishes.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Client 0 (instruction fetch)
  input  logic                  c0_req_i,
  input  logic                  c0_we_i,
  input  logic [ADDR_WIDTH-1:0] c0_addr_i,
  input  logic [DATA_WIDTH-1:0] c0_wdata_i,
  output logic                  c0_gnt_o,
  output logic                  c0_cplt_o,
  output logic [DATA_WIDTH-1:0] c0_rdata_o,
  output logic                  c0_err_o,
  // Client 1 (data)
  input  logic                  c1_req_i,
  input  logic                  c1_we_i,
  input  logic [ADDR_WIDTH-1:0] c1_addr_i,
  input  logic [DATA_WIDTH-1:0] c1_wdata_i,
  output logic                  c1_gnt_o,
  output logic                  c1_cplt_o,
  output logic [DATA_WIDTH-1:0] c1_rdata_o,
  output logic                  c1_err_o,
  // Memory controller
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_in_o,
  output logic                  mem_r_en_o,
  output logic                  mem_w_en_o,
  input  logic                  mem_rdy_i,
  input  logic                  mem_cplt_i,
  input  logic [DATA_WIDTH-1:0] mem_data_out_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Counter value on the last WAIT cycle allowed before the watchdog fires
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ren_q, ren_d;
  logic                  wen_q, wen_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            cplt_q, cplt_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic [1:0] req;
  logic       win;
  logic       win_we;

  assign req    = {c1_req_i, c0_req_i};
  // On a tie the client that was not served last wins
  assign win    = (req == 2'b11) ? ~last_q : req[1];
  assign win_we = win ? c1_we_i : c0_we_i;

  // Next-state and registered-output logic for the IDLE/ISSUE/WAIT sequence
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    gnt_d    = '0;
    cplt_d   = '0;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d      = win;
          addr_d       = win ? c1_addr_i : c0_addr_i;
          wdata_d      = win ? c1_wdata_i : c0_wdata_i;
          ren_d        = ~win_we;
          wen_d        = win_we;
          gnt_d[win]   = 1'b1;
          state_d      = StIssue;
        end
      end

      StIssue: begin
        // Drop the enable right after the accept edge so the controller fires only once
        if ((ren_q | wen_q) & mem_rdy_i) begin
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          cnt_d   = '0;
          state_d = StWait;
        end
      end

      StWait: begin
        if (mem_cplt_i) begin
          // Completion beats a coinciding timeout
          cplt_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b0;
          if (owner_q) begin
            rdata1_d = mem_data_out_i;
          end else begin
            rdata0_d = mem_data_out_i;
          end
          last_d  = owner_q;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          cplt_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
          last_d          = owner_q;
          state_d         = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any transaction silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      gnt_q    <= '0;
      cplt_q   <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      gnt_q    <= gnt_d;
      cplt_q   <= cplt_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign c0_gnt_o      = gnt_q[0];
  assign c1_gnt_o      = gnt_q[1];
  assign c0_cplt_o     = cplt_q[0];
  assign c1_cplt_o     = cplt_q[1];
  assign c0_err_o      = err_q[0];
  assign c1_err_o      = err_q[1];
  assign c0_rdata_o    = rdata0_q;
  assign c1_rdata_o    = rdata1_q;
  assign mem_addr_o    = addr_q;
  assign mem_data_in_o = wdata_q;
  assign mem_r_en_o    = ren_q;
  assign mem_w_en_o    = wen_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized clients/controller, all checked
// every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          c0_req = 1'b0, c0_we = 1'b0, c1_req = 1'b0, c1_we = 1'b0;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
  logic          mem_rdy = 1'b1, mem_cplt = 1'b0;
  logic [DW-1:0] mem_data_out = '0;

  logic          c0_gnt, c0_cplt, c0_err, c1_gnt, c1_cplt, c1_err;
  logic [DW-1:0] c0_rdata, c1_rdata, mem_data_in;
  logic [AW-1:0] mem_addr;
  logic          mem_r_en, mem_w_en;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .c0_req_i      (c0_req),
    .c0_we_i       (c0_we),
    .c0_addr_i     (c0_addr),
    .c0_wdata_i    (c0_wdata),
    .c0_gnt_o      (c0_gnt),
    .c0_cplt_o     (c0_cplt),
    .c0_rdata_o    (c0_rdata),
    .c0_err_o      (c0_err),
    .c1_req_i      (c1_req),
    .c1_we_i       (c1_we),
    .c1_addr_i     (c1_addr),
    .c1_wdata_i    (c1_wdata),
    .c1_gnt_o      (c1_gnt),
    .c1_cplt_o     (c1_cplt),
    .c1_rdata_o    (c1_rdata),
    .c1_err_o      (c1_err),
    .mem_addr_o    (mem_addr),
    .mem_data_in_o (mem_data_in),
    .mem_r_en_o    (mem_r_en),
    .mem_w_en_o    (mem_w_en),
    .mem_rdy_i     (mem_rdy),
    .mem_cplt_i    (mem_cplt),
    .mem_data_out_i(mem_data_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit            m_busy, m_acc;
  int            m_owner, m_last, m_waited;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  bit            e_ren, e_wen;
  bit [1:0]      e_gnt, e_cplt, e_err;
  logic [DW-1:0] e_rdata [2];

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_owner = 0; m_last = 1; m_waited = 0;
    e_addr = '0; e_wdata = '0; e_ren = 0; e_wen = 0;
    e_gnt = '0; e_cplt = '0; e_err = '0;
    e_rdata[0] = '0; e_rdata[1] = '0;
  endtask

  task automatic model_finish(input bit timed_out);
    e_cplt[m_owner] = 1'b1;
    e_err[m_owner]  = timed_out;
    if (!timed_out) e_rdata[m_owner] = mem_data_out;
    m_last = m_owner;
    m_busy = 0;
  endtask

  task automatic model_step();
    int w;
    bit we;
    e_gnt  = '0;
    e_cplt = '0;
    if (!m_busy) begin
      if (c0_req || c1_req) begin
        if (c0_req && c1_req) w = 1 - m_last;
        else                  w = c1_req ? 1 : 0;
        we       = (w == 1) ? c1_we : c0_we;
        e_addr   = (w == 1) ? c1_addr : c0_addr;
        e_wdata  = (w == 1) ? c1_wdata : c0_wdata;
        e_ren    = !we;
        e_wen    = we;
        e_gnt[w] = 1'b1;
        m_owner  = w;
        m_busy   = 1;
        m_acc    = 0;
      end
    end else if (!m_acc) begin
      if (mem_rdy) begin
        m_acc    = 1;
        m_waited = 0;
        e_ren    = 0;
        e_wen    = 0;
      end
    end else begin
      m_waited++;
      if (mem_cplt)            model_finish(1'b0);
      else if (m_waited == TO) model_finish(1'b1);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- per-cycle compare and bookkeeping ----------------
  int cyc = 0;
  int ren_hi = 0;
  int wen_hi = 0;
  int cplt_n [2] = '{0, 0};
  int gnt_log [$];

  always @(negedge clk) begin
    cyc++;
    chk("c0_gnt", c0_gnt, e_gnt[0]);
    chk("c1_gnt", c1_gnt, e_gnt[1]);
    chk("c0_cplt", c0_cplt, e_cplt[0]);
    chk("c1_cplt", c1_cplt, e_cplt[1]);
    chk("c0_rdata", c0_rdata, e_rdata[0]);
    chk("c1_rdata", c1_rdata, e_rdata[1]);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_data_in", mem_data_in, e_wdata);
    chk("mem_r_en", mem_r_en, e_ren);
    chk("mem_w_en", mem_w_en, e_wen);
    if (e_cplt[0]) chk("c0_err", c0_err, e_err[0]);
    if (e_cplt[1]) chk("c1_err", c1_err, e_err[1]);
    if (mem_r_en) ren_hi++;
    if (mem_w_en) wen_hi++;
    if (c0_cplt) cplt_n[0]++;
    if (c1_cplt) cplt_n[1]++;
    if (c0_gnt) gnt_log.push_back(0);
    if (c1_gnt) gnt_log.push_back(1);
  end

  // ---------------- stimulus ----------------
  bit auto_ctl = 0, auto_cli = 0, fast = 0, always_req = 0;
  bit ctl_pend = 0;
  int ctl_delay = 0;

  task automatic cli(input logic gnt, input logic req, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, output logic nreq, output logic nwe,
                     output logic [AW-1:0] naddr, output logic [DW-1:0] nwdata);
    nreq = req; nwe = we; naddr = addr; nwdata = wdata;
    if ((req && gnt) || (!req && (always_req || $urandom_range(0, 2) == 0))) begin
      nreq   = (req && gnt) ? (always_req || $urandom_range(0, 1) == 1) : 1'b1;
      nwe    = 1'($urandom_range(0, 1));
      naddr  = AW'($urandom);
      nwdata = DW'($urandom);
    end else if (req && !always_req && $urandom_range(0, 15) == 0) begin
      nreq = 1'b0;
    end
  endtask

  // One clock: land just after the negedge so the compare process has already run
  task automatic cycle();
    @(negedge clk);
    #1;
    if (auto_ctl) begin
      mem_data_out = DW'($urandom);
      if (ctl_pend) begin
        if (ctl_delay == 0) begin
          mem_cplt = 1'b1;
          ctl_pend = 0;
        end else begin
          ctl_delay--;
          mem_cplt = 1'b0;
        end
      end else begin
        mem_cplt = !fast && ($urandom_range(0, 19) == 0);
      end
      mem_rdy = fast || ($urandom_range(0, 3) != 0);
      if ((mem_r_en || mem_w_en) && mem_rdy) begin
        ctl_pend  = 1;
        ctl_delay = fast ? 0 : int'($urandom_range(0, TO + 3));
      end
    end
    if (auto_cli) begin
      cli(c0_gnt, c0_req, c0_we, c0_addr, c0_wdata, c0_req, c0_we, c0_addr, c0_wdata);
      cli(c1_gnt, c1_req, c1_we, c1_addr, c1_wdata, c1_req, c1_we, c1_addr, c1_wdata);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, w0, g, n0, n1;
    bit seen;

    // Reset values
    repeat (3) cycle();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_r_en", mem_r_en, 0);
    chk("rst_c0_gnt", c0_gnt, 0);
    chk("rst_c1_rdata", c1_rdata, 0);
    rst_n = 1'b1;
    cycle();

    // Single read by c0, completion 5 cycles after the accept edge
    c0_req = 1; c0_we = 0; c0_addr = 16'h0040; mem_rdy = 1;
    r0 = ren_hi;
    n1 = cplt_n[1];
    cycle();
    chk("rd_gnt", c0_gnt, 1);
    chk("rd_ren", mem_r_en, 1);
    chk("rd_addr", mem_addr, 16'h0040);
    c0_req = 0;
    cycle();                      // accept edge passed, first WAIT cycle
    repeat (4) cycle();
    mem_cplt = 1; mem_data_out = 16'h1234;
    cycle();
    mem_cplt = 0;
    chk("rd_cplt", c0_cplt, 1);
    chk("rd_rdata", c0_rdata, 16'h1234);
    chk("rd_err", c0_err, 0);
    chk("rd_ren_cycles", ren_hi - r0, 1);
    chk("rd_c1_rdata", c1_rdata, 0);
    chk("rd_c1_no_cplt", cplt_n[1] - n1, 0);
    chk("model_rd_rdata", e_rdata[0], 16'h1234);
    cycle();

    // IO-mapped write by c1, controller completes in the first WAIT cycle
    c1_req = 1; c1_we = 1; c1_addr = 16'h0101; c1_wdata = 16'hBEEF;
    w0 = wen_hi;
    cycle();
    chk("wr_gnt", c1_gnt, 1);
    chk("wr_wen", mem_w_en, 1);
    chk("wr_data", mem_data_in, 16'hBEEF);
    chk("wr_addr", mem_addr, 16'h0101);
    g = cyc;
    c1_req = 0;
    cycle();
    mem_cplt = 1; mem_data_out = 16'h5A5A;
    cycle();
    mem_cplt = 0;
    chk("wr_cplt", c1_cplt, 1);
    // gnt cycle, WAIT cycle, cplt cycle: three cycles counting the gnt cycle
    chk("wr_gnt_to_cplt", cyc - g, 2);
    chk("wr_wen_cycles", wen_hi - w0, 1);
    chk("wr_rdata", c1_rdata, 16'h5A5A);
    chk("wr_c0_rdata_kept", c0_rdata, 16'h1234);
    cycle();

    // Fairness from reset with both clients requesting continuously
    rst_n = 0;
    c0_req = 1; c1_req = 1;
    cycle();
    rst_n = 1;
    n0 = gnt_log.size();
    auto_cli = 1; always_req = 1; auto_ctl = 1; fast = 1;
    repeat (16) cycle();
    chk("fair_count", 32'(gnt_log.size() >= n0 + 4), 1);
    for (int k = 0; k < 4; k++) begin
      if (gnt_log.size() > n0 + k) chk("fair_order", gnt_log[n0 + k], k % 2);
    end
    auto_cli = 0; always_req = 0; c0_req = 0; c1_req = 0;
    repeat (6) cycle();
    auto_ctl = 0; fast = 0; mem_cplt = 0; mem_rdy = 1;
    cycle();

    // Reset with only c1 requesting: granted straight away
    rst_n = 0;
    c1_req = 1; c1_we = 0; c1_addr = 16'h0200;
    cycle();
    rst_n = 1;
    cycle();
    chk("rst_c1_first", c1_gnt, 1);
    c1_req = 0;
    cycle();
    mem_cplt = 1; mem_data_out = 16'h0777;
    cycle();
    mem_cplt = 0;
    cycle();

    // Stall: mem_rdy low for 20 ISSUE cycles, enable held through the accept cycle
    c0_req = 1; c0_we = 0; c0_addr = 16'h0300; mem_rdy = 0;
    r0 = ren_hi;
    n0 = cplt_n[0];
    cycle();
    chk("stall_gnt", c0_gnt, 1);
    c0_req = 0;
    for (int k = 0; k < 20; k++) begin
      chk("stall_ren", mem_r_en, 1);
      cycle();
    end
    chk("stall_ren_last", mem_r_en, 1);
    mem_rdy = 1;
    cycle();
    chk("stall_ren_drop", mem_r_en, 0);
    chk("stall_ren_cycles", ren_hi - r0, 21);
    chk("stall_no_cplt", cplt_n[0] - n0, 0);
    mem_cplt = 1; mem_data_out = 16'hCAFE;
    cycle();
    mem_cplt = 0;
    chk("stall_cplt", c0_cplt, 1);
    chk("stall_rdata", c0_rdata, 16'hCAFE);
    cycle();

    // Watchdog: no completion, err after 8 WAIT cycles, late mem_cplt ignored
    c0_req = 1; c0_we = 0; c0_addr = 16'h0400;
    cycle();
    chk("to_gnt", c0_gnt, 1);
    g = cyc;
    c0_req = 0;
    repeat (8) begin
      cycle();
      chk("to_no_early_cplt", c0_cplt, 0);
    end
    cycle();
    chk("to_cplt", c0_cplt, 1);
    chk("to_err", c0_err, 1);
    chk("to_latency", cyc - g, 9);
    chk("to_rdata_kept", c0_rdata, 16'hCAFE);
    n0 = cplt_n[0];
    mem_cplt = 1; mem_data_out = 16'hDEAD;
    cycle();
    mem_cplt = 0;
    repeat (2) cycle();
    chk("to_late_ignored", cplt_n[0] - n0, 0);
    chk("to_late_rdata", c0_rdata, 16'hCAFE);

    // Reset mid-WAIT with c1 pending; afterwards port 0 wins the tie again
    c0_req = 1; c0_addr = 16'h0500;
    cycle();
    c0_req = 0;
    cycle();
    c1_req = 1; c1_we = 0; c1_addr = 16'h0600;
    cycle();
    #1 rst_n = 0;
    #1;
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_r_en", mem_r_en, 0);
    chk("arst_c0_rdata", c0_rdata, 0);
    chk("arst_c1_rdata", c1_rdata, 0);
    c0_req = 1;
    cycle();
    rst_n = 1;
    cycle();
    chk("prio_c0_first", c0_gnt, 1);
    chk("prio_c1_waits", c1_gnt, 0);
    c0_req = 0;
    cycle();
    mem_cplt = 1;
    cycle();
    mem_cplt = 0;
    seen = 0;
    for (int k = 0; k < 5 && !seen; k++) begin
      cycle();
      seen = c1_gnt;
    end
    chk("prio_c1_served", seen, 1);
    c1_req = 0;
    cycle();
    mem_cplt = 1;
    cycle();
    mem_cplt = 0;
    cycle();

    // Randomized traffic with occasional asynchronous resets
    n0 = gnt_log.size();
    auto_cli = 1; auto_ctl = 1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if ($urandom_range(0, 399) == 0) begin
        #1 rst_n = 0;
        #1;
        chk("rand_arst_ren", mem_r_en, 0);
        chk("rand_arst_cplt", c0_cplt, 0);
        cycle();
        rst_n = 1;
      end
    end
    chk("rand_activity", 32'(gnt_log.size() > n0 + 100), 1);
    auto_cli = 0; auto_ctl = 0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
